program_loader: RTL and testbench

Sequencer that reloads the MC14500B text memory from a byte stream at run time. It holds the processor core in reset while loading, writes the stream word by word through the text-memory write port, and releases the core once the program is complete. It sits between a byte source (UART/host bridge) and the text-memory write port (program_write/program_cmd) plus an address mux that selects the loader address over the program counter while the core is held.

---
 rtl/program_loader.sv | 196 +++++++++++++++++++
 tb/tb_program_loader.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Reloads the MC14500B text memory from a byte stream while holding the core in reset.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader #(
   parameter int ADDR = 8,
   parameter int CODE = 4,
   parameter int WORD = ADDR + CODE
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic [7:0]      rx_data,
   input  logic            rx_valid,
   output logic            rx_ready,
   output logic            program_write,
   output logic [ADDR-1:0] program_addr,
   output logic [WORD-1:0] program_cmd,
   output logic            cpu_hold,
   output logic            busy,
   output logic            done,
   output logic            error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_HI,
      S_LO,
      S_WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_FINISH
   } state_t;

   state_t          state_q, state_d;
   logic [ADDR:0]   remaining_q, remaining_d;
   logic [ADDR-1:0] addr_q, addr_d;
   logic [WORD-1:0] cmd_q, cmd_d;
   logic [WORD-9:0] hi_q, hi_d;
   logic            rx_ready_q, rx_ready_d;
   logic            write_q, write_d;
   logic            hold_q, hold_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            error_q, error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]      acc_q, acc_d;
`endif

   logic xfer;
   assign xfer = rx_valid && rx_ready_q;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      addr_d      = addr_q;
      cmd_d       = cmd_q;
      hi_d        = hi_q;
      hold_d      = hold_q;
      done_d      = done_q;
      error_d     = error_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      acc_d       = acc_q;
      if (xfer) begin
         acc_d = acc_q ^ rx_data;
      end
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_HDR;
               hold_d  = 1'b1;
               done_d  = 1'b0;
               error_d = 1'b0;
               addr_d  = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               acc_d   = '0;
`endif
            end
         end
         S_HDR: begin
            if (xfer) begin
               // A zero header means a full 256-word image
               remaining_d = (rx_data == 8'd0) ? (ADDR+1)'(256) : (ADDR+1)'(rx_data);
               state_d     = S_HI;
            end
         end
         S_HI: begin
            if (xfer) begin
               hi_d    = rx_data[WORD-9:0];
               state_d = S_LO;
            end
         end
         S_LO: begin
            if (xfer) begin
               cmd_d   = {hi_q, rx_data};
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (remaining_q == (ADDR+1)'(1)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               state_d = S_CSUM;
`else
               state_d = S_FINISH;
`endif
            end else begin
               addr_d      = addr_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               state_d     = S_HI;
            end
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (xfer) begin
               if ((acc_q ^ rx_data) == 8'd0) begin
                  state_d = S_FINISH;
               end else begin
                  state_d = S_IDLE;
                  error_d = 1'b1;
               end
            end
         end
`endif
         S_FINISH: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort keeps the core held so a partial image never executes
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         error_d = 1'b1;
         done_d  = 1'b0;
         hold_d  = 1'b1;
      end

      rx_ready_d = (state_d == S_HDR) || (state_d == S_HI) || (state_d == S_LO);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      rx_ready_d = rx_ready_d || (state_d == S_CSUM);
`endif
      write_d = (state_d == S_WRITE);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         addr_q      <= '0;
         cmd_q       <= '0;
         hi_q        <= '0;
         rx_ready_q  <= 1'b0;
         write_q     <= 1'b0;
         hold_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         acc_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         addr_q      <= addr_d;
         cmd_q       <= cmd_d;
         hi_q        <= hi_d;
         rx_ready_q  <= rx_ready_d;
         write_q     <= write_d;
         hold_q      <= hold_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         acc_q       <= acc_d;
`endif
      end
   end

   assign rx_ready      = rx_ready_q;
   assign program_write = write_q;
   assign program_addr  = addr_q;
   assign program_cmd   = cmd_q;
   assign cpu_hold      = hold_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: random word streams against a queue-based model.
// Checksum scenarios run when PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

   localparam int ADDR = 8;
   localparam int CODE = 4;
   localparam int WORD = ADDR + CODE;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            abort;
   logic [7:0]      rx_data;
   logic            rx_valid;
   logic            rx_ready;
   logic            program_write;
   logic [ADDR-1:0] program_addr;
   logic [WORD-1:0] program_cmd;
   logic            cpu_hold;
   logic            busy;
   logic            done;
   logic            error;

   program_loader #(.ADDR(ADDR), .CODE(CODE), .WORD(WORD)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .program_write(program_write), .program_addr(program_addr),
      .program_cmd(program_cmd), .cpu_hold(cpu_hold), .busy(busy),
      .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int totalCount = 0;
   int badCount   = 0;
   int cyc        = 0;
   int dblCount   = 0;
   logic prevWrite = 1'b0;
   logic [ADDR-1:0] wAddr[$];
   logic [WORD-1:0] wCmd[$];
   int              wCyc[$];
   logic [7:0]      loadHi[$];
   logic [7:0]      loadLo[$];

   // Records every write strobe with the edge index that raised it
   always @(posedge clk) begin
      #1;
      cyc++;
      if (program_write === 1'b1) begin
         wAddr.push_back(program_addr);
         wCmd.push_back(program_cmd);
         wCyc.push_back(cyc);
         if (prevWrite) dblCount++;
      end
      prevWrite = (program_write === 1'b1);
   end

   function automatic logic [5:0] status();
      return {rx_ready, program_write, cpu_hold, busy, done, error};
   endfunction

   function automatic logic [WORD-1:0] model_word(input logic [7:0] hi, input logic [7:0] lo);
      int v;
      v = (int'(hi) % (1 << (WORD - 8))) * 256 + int'(lo);
      return WORD'(v);
   endfunction

   task automatic clear_log();
      wAddr.delete();
      wCmd.delete();
      wCyc.delete();
      dblCount = 0;
   endtask

   task automatic kick();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      totalCount++;
      if (status() !== 6'b101100 || program_addr !== '0) begin
         badCount++;
         $display("[TB] FAIL start_state: got status=%b addr=%0d want status=101100 addr=0", status(), program_addr);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit noise, output bit ok);
      int k;
      k = 0;
      rx_valid = 1'b0;
      while (rx_ready !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      totalCount++;
      if (rx_ready !== 1'b1) begin
         badCount++;
         $display("[TB] FAIL ready_timeout: rx_ready=%b after %0d cycles, want 1", rx_ready, k);
         ok = 1'b0;
         return;
      end
      for (int g = 0; g < gap; g++) begin
         start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         totalCount++;
         if (rx_ready !== 1'b1) begin
            badCount++;
            $display("[TB] FAIL ready_hold: rx_ready=%b during gap, want 1", rx_ready);
         end
      end
      start    = 1'b0;
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      ok = 1'b1;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      totalCount++;
      if (busy !== 1'b0) begin
         badCount++;
         $display("[TB] FAIL idle_timeout: busy=%b, want 0", busy);
      end
   endtask

   // Loads loadHi/loadLo and compares every strobe against the stream model
   task automatic run_load(input int maxGap, input bit noise);
      int n;
      logic [7:0] hdr;
      logic [7:0] csum;
      int loCyc[$];
      bit ok;
      n = loadHi.size();
      clear_log();
      kick();
      hdr  = (n == 256) ? 8'h00 : 8'(n);
      csum = hdr;
      send_byte(hdr, $urandom_range(0, maxGap), noise, ok);
      for (int i = 0; i < n && ok; i++) begin
         send_byte(loadHi[i], $urandom_range(0, maxGap), noise, ok);
         if (ok) send_byte(loadLo[i], $urandom_range(0, maxGap), noise, ok);
         loCyc.push_back(cyc);
         csum = csum ^ loadHi[i] ^ loadLo[i];
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (ok) send_byte(csum, $urandom_range(0, maxGap), noise, ok);
`endif
      if (!ok) begin
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         return;
      end
      wait_idle();
      totalCount++;
      if (status() !== 6'b000010) begin
         badCount++;
         $display("[TB] FAIL load_done: status=%b want 000010", status());
      end
      totalCount++;
      if (wAddr.size() !== n) begin
         badCount++;
         $display("[TB] FAIL write_count: got %0d want %0d", wAddr.size(), n);
      end
      for (int i = 0; i < n && i < wAddr.size(); i++) begin
         totalCount++;
         if (wAddr[i] !== ADDR'(i % 256) || wCmd[i] !== model_word(loadHi[i], loadLo[i]) || wCyc[i] !== loCyc[i]) begin
            badCount++;
            $display("[TB] FAIL word%0d: got addr=%0d cmd=%h cyc=%0d want addr=%0d cmd=%h cyc=%0d",
                     i, wAddr[i], wCmd[i], wCyc[i], i % 256, model_word(loadHi[i], loadLo[i]), loCyc[i]);
         end
      end
      totalCount++;
      if (dblCount !== 0) begin
         badCount++;
         $display("[TB] FAIL strobe_width: %0d multi-cycle strobes, want 0", dblCount);
      end
   endtask

   task automatic fill_random(input int n);
      loadHi.delete();
      loadLo.delete();
      for (int i = 0; i < n; i++) begin
         loadHi.push_back(8'($urandom));
         loadLo.push_back(8'($urandom));
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; abort = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      totalCount++;
      if (status() !== 6'b000000 || program_addr !== '0 || program_cmd !== '0) begin
         badCount++;
         $display("[TB] FAIL reset_state: status=%b addr=%0d cmd=%h want all zero", status(), program_addr, program_cmd);
      end
      clear_log();
      for (int i = 0; i < 4; i++) begin
         rx_valid = 1'b1;
         rx_data  = 8'($urandom);
         @(negedge clk);
         totalCount++;
         if (status() !== 6'b000000) begin
            badCount++;
            $display("[TB] FAIL idle_rx_ignored: status=%b want 000000", status());
         end
      end
      rx_valid = 1'b0;
   endtask

   task automatic test_basic();
      loadHi = '{8'h0A, 8'h03};
      loadLo = '{8'h11, 8'hFF};
      run_load(0, 1'b0);
      totalCount++;
      if (wCmd.size() != 2 || wCmd[0] !== 12'hA11 || wCmd[1] !== 12'h3FF) begin
         badCount++;
         $display("[TB] FAIL basic_cmds: got %0d writes, want A11 then 3FF", wCmd.size());
      end
   endtask

   task automatic test_full256();
      fill_random(256);
      run_load(0, 1'b0);
   endtask

   task automatic test_gaps();
      fill_random(3);
      run_load(0, 1'b0);
      run_load(5, 1'b1);
   endtask

   task automatic test_abort();
      bit ok;
      fill_random(3);
      clear_log();
      kick();
      send_byte(8'h03, 0, 1'b0, ok);
      send_byte(loadHi[0], 0, 1'b0, ok);
      send_byte(loadLo[0], 0, 1'b0, ok);
      send_byte(loadHi[1], 0, 1'b0, ok);
      abort    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = loadLo[1];
      @(negedge clk);
      abort    = 1'b0;
      rx_valid = 1'b0;
      repeat (5) @(negedge clk);
      totalCount++;
      if (wAddr.size() !== 1 || wCmd[0] !== model_word(loadHi[0], loadLo[0])) begin
         badCount++;
         $display("[TB] FAIL abort_writes: got %0d writes, want exactly 1", wAddr.size());
      end
      totalCount++;
      if (status() !== 6'b001001) begin
         badCount++;
         $display("[TB] FAIL abort_state: status=%b want 001001", status());
      end
      fill_random(1);
      run_load(0, 1'b0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
      totalCount++;
      if (status() !== 6'b000010) begin
         badCount++;
         $display("[TB] FAIL idle_abort_ignored: status=%b want 000010", status());
      end
   endtask

   task automatic test_start_abort_same();
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      totalCount++;
      if (status() !== 6'b101100) begin
         badCount++;
         $display("[TB] FAIL start_beats_abort: status=%b want 101100", status());
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      totalCount++;
      if (status() !== 6'b001001) begin
         badCount++;
         $display("[TB] FAIL abort_hdr: status=%b want 001001", status());
      end
   endtask

   task automatic test_reset_midload();
      bit ok;
      kick();
      send_byte(8'h04, 0, 1'b0, ok);
      send_byte(8'h5A, 0, 1'b0, ok);
      reset = 1'b0;
      #1;
      totalCount++;
      if (status() !== 6'b000000 || program_addr !== '0) begin
         badCount++;
         $display("[TB] FAIL async_reset: status=%b addr=%0d want 000000 addr=0", status(), program_addr);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      bit ok;
      logic [7:0] cs [2];
      cs[0] = 8'h24;
      cs[1] = 8'h25;
      for (int r = 0; r < 2; r++) begin
         clear_log();
         kick();
         send_byte(8'h01, 0, 1'b0, ok);
         send_byte(8'h05, 0, 1'b0, ok);
         send_byte(8'h20, 0, 1'b0, ok);
         send_byte(cs[r], 0, 1'b0, ok);
         wait_idle();
         totalCount++;
         if (status() !== ((r == 0) ? 6'b000010 : 6'b001001) || wCmd.size() != 1 || wCmd[0] !== 12'h520) begin
            badCount++;
            $display("[TB] FAIL checksum%0d: status=%b writes=%0d want %b with one write 520",
                     r, status(), wCmd.size(), (r == 0) ? 6'b000010 : 6'b001001);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_full256();
      test_gaps();
      test_abort();
      test_start_abort_same();
      test_reset_midload();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      fill_random(2);
      run_load(2, 1'b1);
      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
